// File: rtl/state_dump_unit_pkg.sv
// mips_dump_pkg: shared definitions for the processor state dump unit.
//   dump_state_e : FSM state encoding
//   DUMP_DATA_W  : default register / data-memory word width
//   SRC_REG/MEM  : out_src encoding of where a streamed word came from
package mips_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_REGS  = 3'd2,
    ST_MEM   = 3'd3,
    ST_FLUSH = 3'd4
  } dump_state_e;

  localparam int   DUMP_DATA_W = 16;
  localparam logic SRC_REG     = 1'b0;
  localparam logic SRC_MEM     = 1'b1;

endpackage

// File: rtl/state_dump_unit_if.sv
// state_dump_unit_if: valid/ready output stream of the state dump unit.
//   out_valid : word present          out_ready : sink accepts the word
//   out_data  : dumped word           out_src   : 0 = register, 1 = memory
//   out_last  : final word of the dump
// Modports: master (dump unit side), slave (stream sink side).
interface state_dump_unit_if #(
  parameter int DATA_W = 16
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_src,
                  output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_src,
                  input out_last, output out_ready);
endinterface

// File: rtl/state_dump_unit.sv
// state_dump_unit: freezes the processor, then streams every register
// followed by every data-memory word through a valid/ready stream.
// Ports:
//   clock, reset_n      : clock (rising edge), async active-low reset
//   start               : one-cycle dump request (ignored while busy)
//   halt_cpu, busy      : high in every state except IDLE
//   reg_rd_addr/data    : register-file read port (combinational data)
//   mem_rd_addr/data    : data-memory read port (combinational data)
//   o_stream            : output stream (state_dump_unit_if.master)
//   done                : one-cycle pulse when the final word is accepted
// Build option: define STATE_DUMP_CHECKSUM_EN to append a checksum word
// (sum mod 2^DATA_W of all dumped words, src = memory) carrying out_last.
//
// state | meaning
// IDLE  | waiting for start, processor running
// HALT  | one cycle to let the halted processor settle
// REGS  | streaming register file, index = register number
// MEM   | streaming data memory, index = word address
// FLUSH | waiting for the final word to be accepted
module state_dump_unit
  import mips_dump_pkg::*;
#(
  parameter int DATA_W     = DUMP_DATA_W,
  parameter int REG_COUNT  = 16,
  parameter int DMEM_DEPTH = 64,
  localparam int MEM_AW    = $clog2(DMEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              halt_cpu,
  output logic [3:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  state_dump_unit_if.master o_stream,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (MEM_AW > 4) ? MEM_AW : 4;

  dump_state_e       r_state, w_next;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_src;
  logic              r_last;
  logic              w_accept;
  logic              w_load;
  logic              w_reg_end;
  logic              w_mem_end;
`ifdef STATE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_csum_loaded;
`endif

  assign w_accept  = r_valid && o_stream.out_ready;
  // Output register takes a new word when empty or when its word leaves.
  assign w_load    = ((r_state == ST_REGS) || (r_state == ST_MEM)) &&
                     (!r_valid || o_stream.out_ready);
  assign w_reg_end = (r_state == ST_REGS) && (r_idx == IDX_W'(REG_COUNT - 1));
  assign w_mem_end = (r_state == ST_MEM) && (r_idx == IDX_W'(DMEM_DEPTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_HALT;
      ST_HALT:  w_next = ST_REGS;
      ST_REGS:  if (w_load && w_reg_end) w_next = ST_MEM;
      ST_MEM:   if (w_load && w_mem_end) w_next = ST_FLUSH;
      ST_FLUSH: begin
        // r_last is only ever set on the final word of the stream
        if (w_accept && r_last) begin
          w_next = ST_IDLE;
          done   = 1'b1;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= SRC_REG;
      r_last  <= 1'b0;
`ifdef STATE_DUMP_CHECKSUM_EN
      r_sum         <= '0;
      r_csum_loaded <= 1'b0;
`endif
    end else if (r_state == ST_HALT) begin
      r_idx <= '0;
`ifdef STATE_DUMP_CHECKSUM_EN
      r_sum         <= '0;
      r_csum_loaded <= 1'b0;
`endif
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= (r_state == ST_REGS) ? reg_rd_data : mem_rd_data;
      r_src   <= (r_state == ST_REGS) ? SRC_REG : SRC_MEM;
`ifdef STATE_DUMP_CHECKSUM_EN
      r_last  <= 1'b0;
      r_sum   <= r_sum + ((r_state == ST_REGS) ? reg_rd_data : mem_rd_data);
`else
      r_last  <= w_mem_end;
`endif
      r_idx   <= (w_reg_end || w_mem_end) ? '0 : r_idx + IDX_W'(1);
    end else if (r_state == ST_FLUSH) begin
`ifdef STATE_DUMP_CHECKSUM_EN
      if (!r_csum_loaded && (!r_valid || o_stream.out_ready)) begin
        r_valid       <= 1'b1;
        r_data        <= r_sum;
        r_src         <= SRC_MEM;
        r_last        <= 1'b1;
        r_csum_loaded <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
`else
      if (w_accept) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
`endif
    end
  end

  assign halt_cpu           = (r_state != ST_IDLE);
  assign busy               = (r_state != ST_IDLE);
  assign reg_rd_addr        = r_idx[3:0];
  assign mem_rd_addr        = r_idx[MEM_AW-1:0];
  assign o_stream.out_valid = r_valid;
  assign o_stream.out_data  = r_data;
  assign o_stream.out_src   = r_src;
  assign o_stream.out_last  = r_last;

endmodule
